// File: rtl/tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tx_frame_arbiter
//
// Shares the single UART-TX FIFO write port between two requesters:
//   - register-file read responses : 1-byte frame
//   - ALU results                  : 2-byte frame, low byte first
// Round-robin arbitration between simultaneous requests, REQ/ACK handshake
// per requester, FIFO_FULL backpressure. REF_CLK domain.
//
// Handshake: a requester raises REQ together with stable data and holds both
// until its ACK. ACK is a registered one-cycle pulse during the first cycle
// of SEND_LO; the requester drops REQ on the edge that ends that cycle. REQ
// is only looked at in IDLE. WR_INC is the FIFO write strobe: one byte is
// written in every cycle WR_INC is high (WR_INC = BUSY && !FIFO_FULL).
//
// Optional feature (macro TXA_CHECKSUM_EN): each frame is followed by an XOR
// checksum byte of its data bytes, sent from the extra state SEND_CHK.
//
// Ports:
//   CLK        system clock (REF_CLK)
//   RST        asynchronous active-low reset
//   RD_REQ     register-read request, RD_DATA held with it
//   RD_DATA    register-read byte
//   RD_ACK     one-cycle pulse, RD_DATA captured
//   ALU_REQ    ALU result request, ALU_DATA held with it
//   ALU_DATA   ALU result (2*WIDTH)
//   ALU_ACK    one-cycle pulse, ALU_DATA captured
//   FIFO_FULL  FIFO write side full
//   WR_DATA    FIFO write data (0 in IDLE)
//   WR_INC     FIFO write strobe
//   BUSY       high in any state other than IDLE
//   FRAME_CNT  completed frame count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module tx_frame_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RD_REQ,
  input  logic [WIDTH-1:0]   RD_DATA,
  output logic               RD_ACK,
  input  logic               ALU_REQ,
  input  logic [2*WIDTH-1:0] ALU_DATA,
  output logic               ALU_ACK,
  input  logic               FIFO_FULL,
  output logic [WIDTH-1:0]   WR_DATA,
  output logic               WR_INC,
  output logic               BUSY,
  output logic [7:0]         FRAME_CNT
);

`ifdef TXA_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_LO  = 2'd1,
    SEND_HI  = 2'd2,
    SEND_CHK = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;
`endif

  // last_grant encoding: 0 = register read, 1 = ALU
  localparam logic GRANT_RD  = 1'b0;
  localparam logic GRANT_ALU = 1'b1;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   hold_q, hold_d;
  logic                 two_byte_q, two_byte_d;
  logic                 last_grant_q, last_grant_d;
  logic                 rd_ack_q, rd_ack_d;
  logic                 alu_ack_q, alu_ack_d;
  logic [7:0]           frame_cnt_q;
  logic                 frame_done;
  logic                 grant_rd, grant_alu;
  logic [WIDTH-1:0]     wr_data;
  logic                 wr_inc;

  // Round robin: on a tie the requester not served last time wins.
  // last_grant resets to ALU so that RD wins the first tie.
  assign grant_rd  = RD_REQ && (!ALU_REQ || (last_grant_q == GRANT_ALU));
  assign grant_alu = ALU_REQ && !grant_rd;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      two_byte_q   <= 1'b0;
      last_grant_q <= GRANT_ALU;
      rd_ack_q     <= 1'b0;
      alu_ack_q    <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      two_byte_q   <= two_byte_d;
      last_grant_q <= last_grant_d;
      rd_ack_q     <= rd_ack_d;
      alu_ack_q    <= alu_ack_d;
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    two_byte_d   = two_byte_q;
    last_grant_d = last_grant_q;
    rd_ack_d     = 1'b0;
    alu_ack_d    = 1'b0;
    wr_data      = '0;
    wr_inc       = 1'b0;
    frame_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          hold_d       = {{WIDTH{1'b0}}, RD_DATA};
          two_byte_d   = 1'b0;
          last_grant_d = GRANT_RD;
          rd_ack_d     = 1'b1;
          state_d      = SEND_LO;
        end else if (grant_alu) begin
          hold_d       = ALU_DATA;
          two_byte_d   = 1'b1;
          last_grant_d = GRANT_ALU;
          alu_ack_d    = 1'b1;
          state_d      = SEND_LO;
        end
      end

      SEND_LO: begin
        wr_data = hold_q[WIDTH-1:0];
        wr_inc  = !FIFO_FULL;
        if (!FIFO_FULL) begin
          if (two_byte_q) begin
            state_d = SEND_HI;
          end else begin
`ifdef TXA_CHECKSUM_EN
            state_d = SEND_CHK;
`else
            state_d    = IDLE;
            frame_done = 1'b1;
`endif
          end
        end
      end

      SEND_HI: begin
        wr_data = hold_q[2*WIDTH-1:WIDTH];
        wr_inc  = !FIFO_FULL;
        if (!FIFO_FULL) begin
`ifdef TXA_CHECKSUM_EN
          state_d = SEND_CHK;
`else
          state_d    = IDLE;
          frame_done = 1'b1;
`endif
        end
      end

`ifdef TXA_CHECKSUM_EN
      SEND_CHK: begin
        // High byte is cleared for 1-byte frames, so lo^hi covers both types.
        wr_data = hold_q[WIDTH-1:0] ^ hold_q[2*WIDTH-1:WIDTH];
        wr_inc  = !FIFO_FULL;
        if (!FIFO_FULL) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign RD_ACK    = rd_ack_q;
  assign ALU_ACK   = alu_ack_q;
  assign WR_DATA   = wr_data;
  assign WR_INC    = wr_inc;
  assign BUSY      = (state_q != IDLE);
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_arbiter
//
// Table of per-cycle vectors: inputs are driven on the falling edge and the
// outputs are compared 1 ns later, i.e. they show the state left by the
// previous rising edge combined with the current inputs. A hand-written
// sequence then sends 256 register-read frames with a write scoreboard and
// checks the FRAME_CNT wrap. Honours TXA_CHECKSUM_EN when defined.
// -----------------------------------------------------------------------------
module tb_tx_frame_arbiter;

  logic        CLK;
  logic        RST;
  logic        RD_REQ;
  logic [7:0]  RD_DATA;
  logic        RD_ACK;
  logic        ALU_REQ;
  logic [15:0] ALU_DATA;
  logic        ALU_ACK;
  logic        FIFO_FULL;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        BUSY;
  logic [7:0]  FRAME_CNT;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- clock/reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  tx_frame_arbiter #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RD_REQ    (RD_REQ),
    .RD_DATA   (RD_DATA),
    .RD_ACK    (RD_ACK),
    .ALU_REQ   (ALU_REQ),
    .ALU_DATA  (ALU_DATA),
    .ALU_ACK   (ALU_ACK),
    .FIFO_FULL (FIFO_FULL),
    .WR_DATA   (WR_DATA),
    .WR_INC    (WR_INC),
    .BUSY      (BUSY),
    .FRAME_CNT (FRAME_CNT)
  );

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        rst;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        alu_req;
    logic [15:0] alu_data;
    logic        full;
    logic        exp_inc;
    logic [7:0]  exp_data;
    logic        exp_rack;
    logic        exp_aack;
    logic        exp_busy;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rq, input logic [7:0] rd,
                     input logic aq, input logic [15:0] ad, input logic full,
                     input logic inc, input logic [7:0] wd, input logic ra,
                     input logic aa, input logic busy, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.rd_req = rq; v.rd_data = rd; v.alu_req = aq;
    v.alu_data = ad; v.full = full; v.exp_inc = inc; v.exp_data = wd;
    v.exp_rack = ra; v.exp_aack = aa; v.exp_busy = busy; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  logic       sb_en = 1'b0;

  always @(negedge CLK) begin
    #2;
    if (sb_en && WR_INC) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_write got WR_DATA=%02h with nothing expected", WR_DATA);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (WR_DATA !== e) begin
          errors++;
          $display("FAIL sb_write got WR_DATA=%02h expected %02h", WR_DATA, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send_rd(input logic [7:0] d);
    bit done;
    @(negedge CLK);
    RD_REQ  = 1'b1;
    RD_DATA = d;
    @(negedge CLK);   // ACK cycle
    RD_REQ  = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      #1;
      if (!BUSY) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL rd_frame_timeout data=%02h BUSY still %0b after 8 cycles", d, BUSY);
    end
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    logic [19:0] got;
    logic [19:0] exp;

    RST = 1'b0; RD_REQ = 1'b0; RD_DATA = '0;
    ALU_REQ = 1'b0; ALU_DATA = '0; FIFO_FULL = 1'b0;

    //   rst rq rd     aq ad        full | inc wd     ra aa busy cnt
`ifndef TXA_CHECKSUM_EN
    add(0, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd0);  // reset state
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd0);
    // single RD 0x5A
    add(1, 1, 8'h5A, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd0);
    add(1, 1, 8'h5A, 0, 16'h0000, 0,   1, 8'h5A, 1, 0, 1, 8'd0);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd1);
    // single ALU 0x1234
    add(1, 0, 8'h00, 1, 16'h1234, 0,   0, 8'h00, 0, 0, 0, 8'd1);
    add(1, 0, 8'h00, 1, 16'h1234, 0,   1, 8'h34, 0, 1, 1, 8'd1);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h12, 0, 0, 1, 8'd1);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd2);
    // reset, then simultaneous RD 0x11 / ALU 0xABCD: RD first
    add(0, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd0);
    add(1, 1, 8'h11, 1, 16'hABCD, 0,   0, 8'h00, 0, 0, 0, 8'd0);
    add(1, 1, 8'h11, 1, 16'hABCD, 0,   1, 8'h11, 1, 0, 1, 8'd0);
    add(1, 0, 8'h00, 1, 16'hABCD, 0,   0, 8'h00, 0, 0, 0, 8'd1);
    add(1, 0, 8'h00, 1, 16'hABCD, 0,   1, 8'hCD, 0, 1, 1, 8'd1);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'hAB, 0, 0, 1, 8'd1);
    // repeat: ALU was last, so RD again first
    add(1, 1, 8'h11, 1, 16'hABCD, 0,   0, 8'h00, 0, 0, 0, 8'd2);
    add(1, 1, 8'h11, 1, 16'hABCD, 0,   1, 8'h11, 1, 0, 1, 8'd2);
    add(1, 0, 8'h00, 1, 16'hABCD, 0,   0, 8'h00, 0, 0, 0, 8'd3);
    add(1, 0, 8'h00, 1, 16'hABCD, 0,   1, 8'hCD, 0, 1, 1, 8'd3);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'hAB, 0, 0, 1, 8'd3);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd4);
    // ALU 0x00FF, FIFO full 3 cycles in SEND_HI
    add(1, 0, 8'h00, 1, 16'h00FF, 0,   0, 8'h00, 0, 0, 0, 8'd4);
    add(1, 0, 8'h00, 1, 16'h00FF, 0,   1, 8'hFF, 0, 1, 1, 8'd4);
    add(1, 0, 8'h00, 0, 16'h0000, 1,   0, 8'h00, 0, 0, 1, 8'd4);
    add(1, 0, 8'h00, 0, 16'h0000, 1,   0, 8'h00, 0, 0, 1, 8'd4);
    add(1, 0, 8'h00, 0, 16'h0000, 1,   0, 8'h00, 0, 0, 1, 8'd4);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h00, 0, 0, 1, 8'd4);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd5);
    // RD 0x3C stalled in SEND_LO: ACK only on the first cycle
    add(1, 1, 8'h3C, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd5);
    add(1, 1, 8'h3C, 0, 16'h0000, 1,   0, 8'h3C, 1, 0, 1, 8'd5);
    add(1, 0, 8'h00, 0, 16'h0000, 1,   0, 8'h3C, 0, 0, 1, 8'd5);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h3C, 0, 0, 1, 8'd5);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd6);
    // ALU 0xBEEF, reset during SEND_HI, then a clean RD 0xA5
    add(1, 0, 8'h00, 1, 16'hBEEF, 0,   0, 8'h00, 0, 0, 0, 8'd6);
    add(1, 0, 8'h00, 1, 16'hBEEF, 0,   1, 8'hEF, 0, 1, 1, 8'd6);
    add(0, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd0);
    add(1, 1, 8'hA5, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd0);
    add(1, 1, 8'hA5, 0, 16'h0000, 0,   1, 8'hA5, 1, 0, 1, 8'd0);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd1);
`else
    add(0, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd0);  // reset state
    // ALU 0x0F3C -> 3C, 0F, 33
    add(1, 0, 8'h00, 1, 16'h0F3C, 0,   0, 8'h00, 0, 0, 0, 8'd0);
    add(1, 0, 8'h00, 1, 16'h0F3C, 0,   1, 8'h3C, 0, 1, 1, 8'd0);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h0F, 0, 0, 1, 8'd0);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h33, 0, 0, 1, 8'd0);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd1);
    // RD 0x80 -> 80, 80
    add(1, 1, 8'h80, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd1);
    add(1, 1, 8'h80, 0, 16'h0000, 0,   1, 8'h80, 1, 0, 1, 8'd1);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h80, 0, 0, 1, 8'd1);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd2);
    // RD 0x41 with checksum stalled one cycle
    add(1, 1, 8'h41, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd2);
    add(1, 1, 8'h41, 0, 16'h0000, 0,   1, 8'h41, 1, 0, 1, 8'd2);
    add(1, 0, 8'h00, 0, 16'h0000, 1,   0, 8'h41, 0, 0, 1, 8'd2);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   1, 8'h41, 0, 0, 1, 8'd2);
    add(1, 0, 8'h00, 0, 16'h0000, 0,   0, 8'h00, 0, 0, 0, 8'd3);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RST       = vecs[i].rst;
      RD_REQ    = vecs[i].rd_req;
      RD_DATA   = vecs[i].rd_data;
      ALU_REQ   = vecs[i].alu_req;
      ALU_DATA  = vecs[i].alu_data;
      FIFO_FULL = vecs[i].full;
      #1;
      got = {WR_INC, WR_DATA, RD_ACK, ALU_ACK, BUSY, FRAME_CNT};
      exp = {vecs[i].exp_inc, vecs[i].exp_data, vecs[i].exp_rack,
             vecs[i].exp_aack, vecs[i].exp_busy, vecs[i].exp_cnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d {inc,data,rack,aack,busy,cnt} got {%b,%02h,%b,%b,%b,%0d} expected {%b,%02h,%b,%b,%b,%0d}",
                 i, WR_INC, WR_DATA, RD_ACK, ALU_ACK, BUSY, FRAME_CNT,
                 vecs[i].exp_inc, vecs[i].exp_data, vecs[i].exp_rack,
                 vecs[i].exp_aack, vecs[i].exp_busy, vecs[i].exp_cnt);
      end
    end

    // 256 register-read frames from reset: FRAME_CNT reaches 255 then wraps
    @(negedge CLK);
    RST = 1'b0; RD_REQ = 1'b0; ALU_REQ = 1'b0; FIFO_FULL = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    sb_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'(i * 7 + 3);
      exp_q.push_back(d);
`ifdef TXA_CHECKSUM_EN
      exp_q.push_back(d);
`endif
      send_rd(d);
      if (i == 254) begin
        checks++;
        if (FRAME_CNT !== 8'd255) begin
          errors++;
          $display("FAIL cnt_255 got FRAME_CNT=%0d expected 255", FRAME_CNT);
        end
      end
    end
    checks++;
    if (FRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL cnt_wrap got FRAME_CNT=%0d expected 0", FRAME_CNT);
    end
    @(negedge CLK);
    sb_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d bytes unwritten expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single UART-TX FIFO write port between two requesters.
  - Register-file read responses: 1-byte frame.
  - ALU results: 2-byte frame, LSB first.
- Round-robin arbitration, per-requester REQ/ACK handshake, FIFO_FULL backpressure.
- Sits between the system controller's response paths and the async FIFO write side, in the REF_CLK domain.

Parameters:
- WIDTH, 8, byte width of FIFO data and register-read data; ALU data is 2*WIDTH.

Ports:
- CLK  input  1  system clock (REF_CLK domain)
- RST  input  1  asynchronous active-low reset
- RD_REQ  input  1  register-read response request; held high with RD_DATA until RD_ACK
- RD_DATA  input  WIDTH  register-read byte
- RD_ACK  output  1  one-cycle pulse: RD_DATA captured
- ALU_REQ  input  1  ALU result request; held high with ALU_DATA until ALU_ACK
- ALU_DATA  input  2*WIDTH  ALU result
- ALU_ACK  output  1  one-cycle pulse: ALU_DATA captured
- FIFO_FULL  input  1  FIFO write side full
- WR_DATA  output  WIDTH  FIFO write data
- WR_INC  output  1  FIFO write strobe; one byte per high cycle
- BUSY  output  1  high in any state other than IDLE
- FRAME_CNT  output  8  count of completed frames, wraps 255->0

Behaviour:
- Interface clocking: reset RST, asynchronous, active-low; clock CLK.
- Reset values:
  - State = IDLE, hold register = 0, frame-type flag = 0, last_grant = ALU.
  - All outputs 0: WR_DATA, WR_INC, RD_ACK, ALU_ACK, BUSY, FRAME_CNT.
- States: IDLE, SEND_LO, SEND_HI, SEND_CHK (SEND_CHK exists only with the optional feature).
- IDLE:
  - Only RD_REQ at a rising edge: capture RD_DATA into hold[WIDTH-1:0], clear hold high byte, set type=1-byte, go to SEND_LO.
  - Only ALU_REQ: capture ALU_DATA, set type=2-byte, go to SEND_LO.
  - Both high: grant the requester opposite last_grant. After reset, RD wins first.
  - On every grant, update last_grant.
- ACKs are registered:
  - The granted ACK is high for exactly the first cycle in SEND_LO.
  - The requester drops REQ on the edge ending that cycle.
  - REQ is ignored in every non-IDLE state.
- SEND_LO:
  - WR_DATA = hold[WIDTH-1:0].
  - WR_INC = !FIFO_FULL, combinational from registered state and FIFO_FULL.
  - If FIFO_FULL, stay; WR_DATA keeps the same value.
  - On the write cycle: 2-byte frame -> SEND_HI; 1-byte frame -> IDLE.
- SEND_HI:
  - WR_DATA = hold[2*WIDTH-1:WIDTH], WR_INC = !FIFO_FULL.
  - On the write cycle -> IDLE.
- FRAME_CNT increments on the cycle the last byte of a frame is written.
- Throughput:
  - Grant latency is one cycle from REQ sampled to first WR_INC, if not full.
  - IDLE lasts at least one cycle between frames, so a 1-byte frame takes 2 cycles and a 2-byte frame 3 cycles.
- WR_DATA is 0 in IDLE. WR_INC is never high in IDLE.
- FIFO_FULL rising between bytes of a 2-byte frame: stall in SEND_HI; no byte is dropped or repeated.
- Reset mid-frame:
  - Immediately returns to IDLE; partial frame abandoned; outputs cleared.
  - Requesters are reset from the same RST.
- The requester may change data only after its ACK.

Optional Feature:
- Macro: TXA_CHECKSUM_EN.
- When defined:
  - After the last data byte of each frame, enter SEND_CHK.
  - Emit XOR of all frame data bytes (1-byte: hold[7:0]; 2-byte: lo^hi), honouring FIFO_FULL.
  - FRAME_CNT increments on the checksum write.
  - Frame length becomes 2 or 3 bytes.
- When undefined: SEND_CHK is absent; the last data byte returns to IDLE as above.

Test Plan:
- Reset, then RD_REQ with RD_DATA=0x5A, FIFO_FULL=0 -> RD_ACK pulse 1 cycle; next cycle WR_INC=1 with WR_DATA=0x5A; FRAME_CNT=1; BUSY low after.
- ALU_REQ with ALU_DATA=0x1234 -> ALU_ACK once; two consecutive WR_INC cycles with WR_DATA 0x34 then 0x12; FRAME_CNT +1.
- RD_REQ (0x11) and ALU_REQ (0xABCD) high simultaneously after reset -> FIFO sees 0x11, then 0xCD, 0xAB. Repeat the simultaneous request -> ALU is not served first; order RD, ALU again.
- ALU 0x00FF with FIFO_FULL asserted for 3 cycles after the low byte -> 0xFF written once; WR_INC low 3 cycles; then 0x00 written once; WR_DATA stable while stalled.
- RST low during SEND_HI of ALU 0xBEEF -> all outputs 0 next; only 0xEF was written; a new RD request afterwards completes normally.
- TXA_CHECKSUM_EN defined, ALU 0x0F3C -> writes 0x3C, 0x0F, 0x33. RD 0x80 -> writes 0x80, 0x80. 256 frames -> FRAME_CNT wraps to 0.
